// File: rtl/spi_master_parallel.sv
// Parallel-word SPI master: frames one host word with chip-select and a single
// SCLK pulse, captures the slave's parallel response and hands it back to the host.
module spi_master_parallel #(
    parameter int unsigned NB_BITS  = 32,
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned CS_SETUP = 5,
    parameter int unsigned CS_HOLD  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    output logic [NB_BITS-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_busy,
    output logic [NB_BITS-1:0] o_MOSI,
    output logic               o_SCLK,
    output logic               o_cs,
    input  logic [NB_BITS-1:0] i_MISO
);

    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CNT = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    // Reload values: each phase counts down to zero, so N cycles load N-1.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_HI = 3'd2,
        SCLK_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_ready_d;
    logic               busy_d;
    logic               rx_valid_d;
    logic [NB_BITS-1:0] rx_data_d;
    logic [NB_BITS-1:0] mosi_d;
    logic               sclk_d;
    logic               cs_d;

    // State, shared phase counter and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            o_tx_ready <= 1'b1;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
            o_MOSI     <= '0;
            o_SCLK     <= 1'b0;
            o_cs       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_tx_ready <= tx_ready_d;
            o_busy     <= busy_d;
            o_rx_valid <= rx_valid_d;
            o_rx_data  <= rx_data_d;
            o_MOSI     <= mosi_d;
            o_SCLK     <= sclk_d;
            o_cs       <= cs_d;
        end
    end

    // Next-state, counter and next-output logic; every phase ends when the counter hits zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_ready_d = o_tx_ready;
        busy_d     = o_busy;
        rx_valid_d = 1'b0;
        rx_data_d  = o_rx_data;
        mosi_d     = o_MOSI;
        sclk_d     = o_SCLK;
        cs_d       = o_cs;

        case (state_q)
            IDLE: begin
                if (i_tx_valid && o_tx_ready) begin
                    mosi_d     = i_tx_data;
                    cs_d       = 1'b1;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = SETUP_LD;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LD;
                    state_d = SCLK_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SCLK_HI: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b0;
                    cnt_d   = DIV_LD;
                    state_d = SCLK_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SCLK_LO: begin
                if (cnt_q == '0) begin
                    rx_data_d = i_MISO;
                    cs_d      = 1'b0;
                    mosi_d    = '0;
                    cnt_d     = HOLD_LD;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_parallel.sv
// Directed bench for spi_master_parallel: default-parameter instance (a) and a
// minimum-timing instance (b, all phases one cycle) sharing data/MISO/reset.
module tb_spi_master_parallel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tx_data;
    logic [31:0] miso_in;
    logic        valid_a, valid_b;
    logic        sel;

    logic        rdy_a, rv_a, busy_a, sclk_a, cs_a;
    logic [31:0] rx_a, mosi_a;
    logic        rdy_b, rv_b, busy_b, sclk_b, cs_b;
    logic [31:0] rx_b, mosi_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_master_parallel #(.NB_BITS(32), .CLK_DIV(5), .CS_SETUP(5), .CS_HOLD(5)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_tx_data(tx_data), .i_tx_valid(valid_a),
        .o_tx_ready(rdy_a), .o_rx_data(rx_a), .o_rx_valid(rv_a), .o_busy(busy_a),
        .o_MOSI(mosi_a), .o_SCLK(sclk_a), .o_cs(cs_a), .i_MISO(miso_in)
    );

    spi_master_parallel #(.NB_BITS(32), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_tx_data(tx_data), .i_tx_valid(valid_b),
        .o_tx_ready(rdy_b), .o_rx_data(rx_b), .o_rx_valid(rv_b), .o_busy(busy_b),
        .o_MOSI(mosi_b), .o_SCLK(sclk_b), .o_cs(cs_b), .i_MISO(miso_in)
    );

    // Observed-signal mux so the frame task serves either instance.
    logic        s_cs, s_sclk, s_rv, s_rdy;
    logic [31:0] s_mosi, s_rx;
    assign s_cs   = sel ? cs_b   : cs_a;
    assign s_sclk = sel ? sclk_b : sclk_a;
    assign s_rv   = sel ? rv_b   : rv_a;
    assign s_rdy  = sel ? rdy_b  : rdy_a;
    assign s_mosi = sel ? mosi_b : mosi_a;
    assign s_rx   = sel ? rx_b   : rx_a;

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Run one frame on the selected instance and collect per-cycle observations.
    // Sample k is taken 1 time unit after edge Ek (E0 = accept edge).
    task automatic frame(input logic which, input logic [31:0] data, input logic [31:0] miso,
                         input int ncyc, input int cap, input int poke,
                         output int cs_cnt, output int sclk_cnt, output int sclk_first,
                         output int rv_idx, output int rv_cnt, output int mosi_bad,
                         output logic [31:0] rx_at_rv);
        sel = which;
        cs_cnt = 0; sclk_cnt = 0; sclk_first = -1; rv_idx = -1; rv_cnt = 0; mosi_bad = 0;
        rx_at_rv = '0;
        @(negedge clk);
        tx_data = data;
        miso_in = miso;
        if (which) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        tx_data = 32'hFFFF_0000;
        for (int k = 0; k < ncyc; k++) begin
            if (s_cs) begin
                cs_cnt++;
                if (s_mosi !== data) mosi_bad++;
            end
            if (s_sclk) begin
                sclk_cnt++;
                if (sclk_first < 0) sclk_first = k;
            end
            if (s_rv) begin
                rv_cnt++;
                if (rv_idx < 0) begin
                    rv_idx   = k;
                    rx_at_rv = s_rx;
                end
            end
            if (k == cap) miso_in = ~miso;
            if (k == poke) begin
                tx_data = 32'h1234_5678;
                if (which) valid_b = 1'b1; else valid_a = 1'b1;
            end else if (k == poke + 1) begin
                valid_a = 1'b0; valid_b = 1'b0;
            end
            @(posedge clk); #1;
        end
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    int          cs_cnt, sclk_cnt, sclk_first, rv_idx, rv_cnt, mosi_bad;
    logic [31:0] rx_v;
    int          hi_cnt, acc2, rv_seen;
    logic [31:0] rx_first, rx_second;
    logic        cs_prev;

    initial begin
        rst_n = 1'b0; tx_data = '0; miso_in = '0; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;

        // 1: reset values, then quiet idle
        #12;
        check("rst_mosi",  mosi_a, 32'h0);
        check("rst_sclk",  32'(sclk_a), 32'h0);
        check("rst_cs",    32'(cs_a), 32'h0);
        check("rst_rx",    rx_a, 32'h0);
        check("rst_rv",    32'(rv_a), 32'h0);
        check("rst_ready", 32'(rdy_a), 32'h1);
        check("rst_busy",  32'(busy_a), 32'h0);
        check("rst_ready_b", 32'(rdy_b), 32'h1);
        @(negedge clk); rst_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cs_a || sclk_a || cs_b || sclk_b) hi_cnt++;
        end
        check("idle_quiet", 32'(hi_cnt), 32'h0);

        // 2: single transfer with default timing
        frame(1'b0, 32'hA000_0005, 32'hDEAD_BEEF, 24, 15, -1,
              cs_cnt, sclk_cnt, sclk_first, rv_idx, rv_cnt, mosi_bad, rx_v);
        check("t2_cs_cycles",   32'(cs_cnt), 32'd15);
        check("t2_sclk_high",   32'(sclk_cnt), 32'd5);
        check("t2_sclk_rise",   32'(sclk_first), 32'd5);
        check("t2_mosi_stable", 32'(mosi_bad), 32'd0);
        check("t2_rv_edge",     32'(rv_idx), 32'd20);
        check("t2_rv_pulses",   32'(rv_cnt), 32'd1);
        check("t2_rx_data",     rx_v, 32'hDEAD_BEEF);
        check("t2_rx_hold",     rx_a, 32'hDEAD_BEEF);
        check("t2_ready",       32'(rdy_a), 32'h1);
        check("t2_mosi_idle",   mosi_a, 32'h0);

        // 3: back-to-back with valid held
        sel = 1'b0;
        @(negedge clk);
        tx_data = 32'hAAAA_AAAA; miso_in = 32'h1111_1111; valid_a = 1'b1;
        @(posedge clk); #1;
        tx_data = 32'h5555_5555;
        acc2 = -1; rv_seen = 0; rx_first = '0; rx_second = '0; cs_prev = 1'b1; mosi_bad = 0;
        for (int k = 0; k < 45; k++) begin
            if (!cs_prev && cs_a && acc2 < 0) acc2 = k;
            if (cs_a && k < 15 && mosi_a !== 32'hAAAA_AAAA) mosi_bad++;
            if (cs_a && k >= 21 && k < 36 && mosi_a !== 32'h5555_5555) mosi_bad++;
            if (!cs_a && k >= 15 && k < 21 && mosi_a !== 32'h0) mosi_bad++;
            cs_prev = cs_a;
            if (rv_a) begin
                rv_seen++;
                if (rv_seen == 1) rx_first = rx_a;
                if (rv_seen == 2) rx_second = rx_a;
            end
            if (k == 15) miso_in = 32'h2222_2222;
            if (k == 21) valid_a = 1'b0;
            @(posedge clk); #1;
        end
        check("t3_second_accept", 32'(acc2), 32'd21);
        check("t3_rv_count",      32'(rv_seen), 32'd2);
        check("t3_rx_first",      rx_first, 32'h1111_1111);
        check("t3_rx_second",     rx_second, 32'h2222_2222);
        check("t3_mosi_words",    32'(mosi_bad), 32'd0);

        // 4: request during SCLK_HI is ignored
        frame(1'b0, 32'hC0DE_0004, 32'h0BAD_F00D, 30, 15, 6,
              cs_cnt, sclk_cnt, sclk_first, rv_idx, rv_cnt, mosi_bad, rx_v);
        check("t4_mosi_kept", 32'(mosi_bad), 32'd0);
        check("t4_rv_once",   32'(rv_cnt), 32'd1);
        check("t4_rx_data",   rx_v, 32'h0BAD_F00D);
        check("t4_cs_cycles", 32'(cs_cnt), 32'd15);

        // 5: reset during SCLK_HI
        sel = 1'b0;
        @(negedge clk);
        tx_data = 32'h7777_7777; miso_in = 32'h9999_9999; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("t5_sclk_before", 32'(sclk_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_sclk_drop", 32'(sclk_a), 32'h0);
        check("t5_cs_drop",   32'(cs_a), 32'h0);
        check("t5_mosi_rst",  mosi_a, 32'h0);
        check("t5_ready_rst", 32'(rdy_a), 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0; hi_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rv_a) rv_seen++;
            if (cs_a) hi_cnt++;
        end
        check("t5_no_rv", 32'(rv_seen), 32'd0);
        check("t5_no_cs", 32'(hi_cnt), 32'd0);
        frame(1'b0, 32'h0000_0001, 32'hCAFE_F00D, 24, 15, -1,
              cs_cnt, sclk_cnt, sclk_first, rv_idx, rv_cnt, mosi_bad, rx_v);
        check("t5_after_rv_edge", 32'(rv_idx), 32'd20);
        check("t5_after_rx",      rx_v, 32'hCAFE_F00D);
        check("t5_after_mosi",    32'(mosi_bad), 32'd0);

        // 6: minimum timing instance
        frame(1'b1, 32'h0F0F_1234, 32'h8765_4321, 8, 3, -1,
              cs_cnt, sclk_cnt, sclk_first, rv_idx, rv_cnt, mosi_bad, rx_v);
        check("t6_cs_cycles", 32'(cs_cnt), 32'd3);
        check("t6_sclk_high", 32'(sclk_cnt), 32'd1);
        check("t6_sclk_rise", 32'(sclk_first), 32'd1);
        check("t6_rv_edge",   32'(rv_idx), 32'd4);
        check("t6_rv_pulses", 32'(rv_cnt), 32'd1);
        check("t6_rx_data",   rx_v, 32'h8765_4321);
        check("t6_mosi",      32'(mosi_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
